// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and mode encodings.
// Used by gray_codec_pipe, the async FIFO pointer logic and the bench model.
// The functions work on a 32-bit container (the widest legal code) and mask
// the result to the requested width, so one body serves every WIDTH.
package gray_pkg;

  localparam logic MODE_B2G  = 1'b0;  // binary -> Gray
  localparam logic MODE_G2B  = 1'b1;  // Gray -> binary
  localparam int   MAX_WIDTH = 32;

  // All-ones mask covering the low 'width' bits.
  function automatic logic [MAX_WIDTH-1:0] width_mask(input int width);
    if (width >= MAX_WIDTH) begin
      return '1;
    end
    return (32'd1 << width) - 32'd1;
  endfunction

  // g = b ^ (b >> 1); the top bit of the code passes through unchanged.
  function automatic logic [MAX_WIDTH-1:0] bin2gray_f(input logic [MAX_WIDTH-1:0] b,
                                                      input int width);
    logic [MAX_WIDTH-1:0] b_m;
    b_m = b & width_mask(width);
    return b_m ^ (b_m >> 1);
  endfunction

  // Prefix XOR from the top bit down. Zero bits above 'width' contribute
  // nothing, so scanning the whole container is equivalent.
  function automatic logic [MAX_WIDTH-1:0] gray2bin_f(input logic [MAX_WIDTH-1:0] g,
                                                      input int width);
    logic [MAX_WIDTH-1:0] g_m;
    logic [MAX_WIDTH-1:0] b;
    g_m = g & width_mask(width);
    b   = '0;
    b[MAX_WIDTH-1] = g_m[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g_m[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_codec_pipe_if.sv
// Valid/ready bus of gray_codec_pipe: input word channel plus result channel.
// master = producer/consumer side (testbench or surrounding logic),
// slave  = the codec itself.
interface gray_codec_pipe_if #(
  parameter int WIDTH = 7
);

  logic             in_valid;
  logic             in_ready;
  logic             in_mode;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_mode;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, out_mode, out_data
  );

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, out_mode, out_data
  );

endinterface

// File: rtl/gray_codec_stage.sv
// Generic valid/ready register slice. Holds one payload word; accepts a new
// word whenever it is empty or its current word leaves in the same cycle, so a
// chain of these sustains one word per cycle with a combinational ready path.
module gray_codec_stage #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_data;

  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Load on upstream transfer, empty on downstream transfer, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      // NOTE: the payload is reset too, not just the valid flag, because the
      // output word must read as zero straight after reset.
      r_data  <= '0;
    end else if (i_valid && o_ready) begin
      // NOTE: non-blocking assignments so every stage samples pre-edge values.
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with valid/ready handshake and a
// per-word mode bit. S1 captures the raw word, S2 registers the converted
// result. Optional Gray single-step checker enabled by GRAY_CODEC_STEP_CHK_EN;
// the data path is the same in both builds. Legal WIDTH range is 2..32.
module gray_codec_pipe
  import gray_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic                clk,
  input  logic                rst,
  gray_codec_pipe_if.slave    bus
`ifdef GRAY_CODEC_STEP_CHK_EN
  ,
  output logic                step_err
`endif
);

  localparam int P1_W = 1 + WIDTH;
`ifdef GRAY_CODEC_STEP_CHK_EN
  // S2 also carries the Gray operand so the checker sees it at transfer time.
  localparam int P2_W = 1 + 2 * WIDTH;
`else
  localparam int P2_W = 1 + WIDTH;
`endif

  logic             w_s1_ready;
  logic             w_s1_valid;
  logic [P1_W-1:0]  w_s1_payload;
  logic             w_s1_mode;
  logic [WIDTH-1:0] w_s1_data;
  logic             w_s2_ready;
  logic [WIDTH-1:0] w_conv;
  logic [P2_W-1:0]  w_s2_in;
  logic [P2_W-1:0]  w_s2_payload;

  // Input is refused while reset is held, even though the stages are empty.
  assign bus.in_ready = w_s1_ready && !rst;

  gray_codec_stage #(.PAYLOAD_W(P1_W)) u_s1 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (bus.in_valid),
    .o_ready (w_s1_ready),
    .i_data  ({bus.in_mode, bus.in_data}),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_payload)
  );

  assign w_s1_mode = w_s1_payload[WIDTH];
  assign w_s1_data = w_s1_payload[WIDTH-1:0];

  // Conversion sits between S1 and S2 so the result leaves from a register.
  always_comb begin
    // NOTE: assign a default first so no path leaves w_conv unassigned (latch).
    w_conv = w_s1_data;
    if (w_s1_mode == MODE_B2G) begin
      w_conv = WIDTH'(bin2gray_f(32'(w_s1_data), WIDTH));
    end else begin
      w_conv = WIDTH'(gray2bin_f(32'(w_s1_data), WIDTH));
    end
  end

`ifdef GRAY_CODEC_STEP_CHK_EN
  logic [WIDTH-1:0] w_gray_op;
  // The Gray side of the word: the result in mode 0, the raw input in mode 1.
  assign w_gray_op = (w_s1_mode == MODE_B2G) ? w_conv : w_s1_data;
  assign w_s2_in   = {w_gray_op, w_s1_mode, w_conv};
`else
  assign w_s2_in   = {w_s1_mode, w_conv};
`endif

  gray_codec_stage #(.PAYLOAD_W(P2_W)) u_s2 (
    .clk     (clk),
    .rst     (rst),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_in),
    .o_valid (bus.out_valid),
    .i_ready (bus.out_ready),
    .o_data  (w_s2_payload)
  );

  assign bus.out_mode = w_s2_payload[WIDTH];
  assign bus.out_data = w_s2_payload[WIDTH-1:0];

`ifdef GRAY_CODEC_STEP_CHK_EN
  logic [WIDTH-1:0] w_s2_gray;
  logic [WIDTH-1:0] w_diff;
  logic             w_multi_bit;
  logic [WIDTH-1:0] r_prev_gray;
  logic             r_have_prev;
  logic             r_step_err;

  assign w_s2_gray   = w_s2_payload[2*WIDTH:WIDTH+1];
  assign w_diff      = r_prev_gray ^ w_s2_gray;
  // x & (x-1) is non-zero exactly when x has two or more bits set.
  assign w_multi_bit = |(w_diff & (w_diff - WIDTH'(1)));
  assign step_err    = r_step_err;

  // Track the Gray value of the last output transfer; pulse on a multi-bit step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_gray <= '0;
      r_have_prev <= 1'b0;
      r_step_err  <= 1'b0;
    end else begin
      r_step_err <= 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        r_step_err  <= r_have_prev && w_multi_bit;
        r_prev_gray <= w_s2_gray;
        r_have_prev <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Scoreboard bench for gray_codec_pipe (WIDTH=7). The driver pushes the
// expected result when a word is accepted; an independent monitor pops and
// compares on every output transfer, and also checks hold stability, ready
// behaviour against an occupancy model and (when built with
// GRAY_CODEC_STEP_CHK_EN) the step_err pulse.
module tb_gray_codec_pipe;
  import gray_pkg::*;

  localparam int W = 7;

  typedef struct {
    logic         mode;
    logic [W-1:0] data;
    logic [W-1:0] gray;
  } exp_t;

  logic clk;
  logic rst;
`ifdef GRAY_CODEC_STEP_CHK_EN
  logic step_err;
  int   n_step_pulses = 0;
`endif

  gray_codec_pipe_if #(.WIDTH(W)) bus ();

  gray_codec_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef GRAY_CODEC_STEP_CHK_EN
    ,
    .step_err (step_err)
`endif
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  bit   rand_en  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Offer one word; push its expected result in the cycle it is accepted.
  task automatic send(input logic m, input logic [W-1:0] d, input logic [W-1:0] e);
    bit acc;
    int n;
    acc = 0;
    n   = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = bus.in_ready;
      if (acc) sb.push_back('{mode: m, data: e, gray: (m == MODE_B2G) ? e : d});
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) fail("send_timeout");
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) fail("drain_timeout");
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Random backpressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: scoreboard pop on transfer, hold stability, step_err model.
  initial begin
    bit           hold_v;
    logic [W-1:0] hold_d;
    logic         hold_m;
    exp_t         e;
`ifdef GRAY_CODEC_STEP_CHK_EN
    bit           have_prev;
    logic [W-1:0] prev_g;
    logic         pend_err;
    have_prev = 0;
    prev_g    = '0;
    pend_err  = 0;
`endif
    hold_v = 0;
    hold_d = '0;
    hold_m = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_v = 0;
`ifdef GRAY_CODEC_STEP_CHK_EN
        have_prev = 0;
        pend_err  = 0;
`endif
        continue;
      end
`ifdef GRAY_CODEC_STEP_CHK_EN
      check("step_err", step_err, pend_err);
      pend_err = 0;
`endif
      if (hold_v) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, hold_d);
        check("hold_mode", bus.out_mode, hold_m);
        hold_v = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          fail("unexpected_output");
        end else begin
          e = sb.pop_front();
          check("out_data", bus.out_data, e.data);
          check("out_mode", bus.out_mode, e.mode);
`ifdef GRAY_CODEC_STEP_CHK_EN
          if (have_prev) pend_err = ($countones(prev_g ^ e.gray) > 1);
          prev_g    = e.gray;
          have_prev = 1;
`endif
        end
      end else if (bus.out_valid) begin
        hold_v = 1;
        hold_d = bus.out_data;
        hold_m = bus.out_mode;
      end
    end
  end

  // Occupancy model: in_ready must be low only when two words are held and
  // the downstream is stalled.
  initial begin
    int inflight;
    inflight = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        inflight = 0;
      end else begin
        check("in_ready", bus.in_ready, (inflight < 2) || bus.out_ready);
        inflight += int'(bus.in_valid && bus.in_ready) - int'(bus.out_valid && bus.out_ready);
      end
    end
  end

`ifdef GRAY_CODEC_STEP_CHK_EN
  always @(negedge clk) if (!rst && step_err) n_step_pulses++;
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Directed table for the mixed-mode / random-backpressure phase.
  logic         mix_m[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  logic [W-1:0] mix_d[8] = '{7'h03, 7'h02, 7'h2A, 7'h3F, 7'h10, 7'h18, 7'h64, 7'h56};
  logic [W-1:0] mix_e[8] = '{7'h02, 7'h03, 7'h3F, 7'h2A, 7'h18, 7'h10, 7'h56, 7'h64};

  initial begin
    int t0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_low", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", bus.in_ready, 1);
    check("post_rst_out_valid", bus.out_valid, 0);
    check("post_rst_out_data", bus.out_data, 0);
    check("post_rst_out_mode", bus.out_mode, 0);
`ifdef GRAY_CODEC_STEP_CHK_EN
    check("post_rst_step_err", step_err, 0);
`endif
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible after N+1.
    bus.out_ready = 1'b1;
    send(MODE_B2G, 7'h00, 7'h00);
    @(negedge clk);
    check("latency_n", bus.out_valid, 0);
    @(negedge clk);
    check("latency_n1", bus.out_valid, 1);
    @(posedge clk);
    #1;
    wait_drain();

    // Mode 0 back-to-back, one word per cycle.
    t0 = cyc;
    send(MODE_B2G, 7'h00, 7'h00);
    send(MODE_B2G, 7'h01, 7'h01);
    send(MODE_B2G, 7'h7F, 7'h40);
    send(MODE_B2G, 7'h55, 7'h7F);
    check("throughput_cycles", cyc - t0, 4);
    // Mode 1.
    send(MODE_G2B, 7'h40, 7'h7F);
    send(MODE_G2B, 7'h7F, 7'h55);
    send(MODE_G2B, 7'h01, 7'h01);
    wait_drain();

    // Full sweep: both modes and a Gray round trip.
    for (int v = 0; v < 128; v++) begin
      send(MODE_B2G, 7'(v), 7'(bin2gray_f(32'(v), W)));
      send(MODE_G2B, 7'(v), 7'(gray2bin_f(32'(v), W)));
      send(MODE_G2B, 7'(bin2gray_f(32'(v), W)), 7'(v));
    end
    wait_drain();

    // Alternating modes under random backpressure.
    rand_en = 1;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) send(mix_m[i], mix_d[i], mix_e[i]);
    end
    rand_en = 0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Stall: two words captured, third refused until release.
    bus.out_ready = 1'b0;
    send(MODE_B2G, 7'h05, 7'h07);
    send(MODE_G2B, 7'h07, 7'h05);
    bus.in_valid = 1'b1;
    bus.in_mode  = MODE_B2G;
    bus.in_data  = 7'h7E;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", bus.in_ready, 1);
    if (bus.in_ready) sb.push_back('{mode: MODE_B2G, data: 7'h41, gray: 7'h41});
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      check("drain_consecutive", bus.out_valid, 1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
    wait_drain();

    // Reset with two words in flight.
    bus.out_ready = 1'b0;
    send(MODE_B2G, 7'h01, 7'h01);
    send(MODE_B2G, 7'h02, 7'h03);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(MODE_B2G, 7'h12, 7'h1B);
    wait_drain();

`ifdef GRAY_CODEC_STEP_CHK_EN
    // Gray counter stream with wrap: never a multi-bit step.
    pulse_reset();
    bus.out_ready = 1'b1;
    n_step_pulses = 0;
    for (int v = 0; v < 128; v++) send(MODE_B2G, 7'(v), 7'(bin2gray_f(32'(v), W)));
    send(MODE_B2G, 7'h00, 7'h00);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("step_count_counter", n_step_pulses, 0);
    // Gray 0x00 then 0x03: exactly one pulse.
    n_step_pulses = 0;
    send(MODE_G2B, 7'h00, 7'h00);
    send(MODE_G2B, 7'h03, 7'h02);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("step_count_jump", n_step_pulses, 1);
`endif

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gray_codec_pipe.md
# gray_codec_pipe

Parametrised, pipelined binary↔Gray converter with valid/ready handshake and per-transaction mode select. Replaces the fixed 7-bit combinational binary-to-Gray converter wherever Gray pointers or counters cross into the async FIFO and pointer-compare logic. Adds Gray-to-binary decode, backpressure, registered outputs and an optional single-bit-step checker for pointer streams.

## Interface
- WIDTH, 7, code width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_mode  input  1  0 = binary→Gray, 1 = Gray→binary
- in_data  input  WIDTH  word to convert
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts result
- out_mode  output  1  mode the result was produced with
- out_data  output  WIDTH  converted word
- step_err  output  1  Gray step violation; port exists only with GRAY_CODEC_STEP_CHK_EN

## Operation
- Two register stages, S1 (capture) and S2 (result). Each holds valid, mode, data.
- S1 captures in_mode and in_data unmodified on in_valid && in_ready.
- S2 computes and registers the result when S1 advances:
  - mode 0: g = b ^ (b >> 1).
  - mode 1: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i] for i = WIDTH-2 down to 0. This is a full prefix XOR.
- Transfer rule for both ports: a transfer occurs when valid && ready are high at the same rising edge.
- Stage ready: s2_ready = !s2_valid || out_ready; s1_ready = !s1_valid || s2_ready; in_ready = s1_ready.
- in_ready is combinational from out_ready. No combinational path runs from in_valid to out_valid.
- Words leave in acceptance order. Modes may be mixed freely, back to back.
- No word is dropped or duplicated under any pattern of out_ready.
- With out_valid high and out_ready low, out_data and out_mode hold stable.
- Width rules: all arithmetic is WIDTH bits, with no sign or carry. The top bit passes through unchanged in both modes.

## Timing
- Reset: in_ready = 0 during reset. After reset, in_ready = 1, out_valid = 0, out_data = 0, out_mode = 0 and step_err = 0. All stage valids clear.
- Latency: word accepted at edge N appears with out_valid = 1 after edge N+1 and can transfer at edge N+2, given no backpressure.
- Throughput: 1 word per cycle while out_ready stays high.
- Stall: with out_ready low, two words are held (S2, then S1) and in_ready falls.
  - When out_ready rises, in_ready rises in the same cycle.
  - The held words then drain one per cycle.
- Simultaneous events: in a cycle where S2 empties and S1 refills, both happen at the same edge.
- Reset mid-operation: all in-flight words are discarded. The next output is the first word accepted after reset.

## Configuration
- Macro: GRAY_CODEC_STEP_CHK_EN.
- Defined:
  - The block keeps the Gray value of the last output transfer plus a "have_prev" flag. The Gray value is out_data in mode 0 and the original input in mode 1. Because of this, S2 also carries the Gray operand.
  - step_err is registered and high in the cycle following an output transfer whose Gray value differs from the previous one in more than one bit.
  - Hamming distance 0 or 1 is legal, so repeats are allowed.
  - The first transfer after reset sets have_prev and is never flagged.
  - step_err is a one-cycle pulse per violating transfer. Reset clears have_prev and step_err.
- Undefined: no step_err port, no tracking registers. The data path is identical in both builds.

## Structure
- Shared package gray_pkg:
  - MODE_B2G = 1'b0 and MODE_G2B = 1'b1 constants.
  - Functions bin2gray_f(WIDTH) and gray2bin_f(WIDTH), reused by the FIFO pointer logic and the testbench model.
- One sub-module, gray_codec_stage: a generic valid/ready register slice parametrised by payload width. It is instantiated for S1 and S2, and the conversion is applied at the S2 input.
- The step checker lives in the top level inside the macro guard.

## Test plan
- WIDTH=7, out_ready=1: mode 0 inputs 0x00, 0x01, 0x7F, 0x55 → outputs 0x00, 0x01, 0x40, 0x7F two cycles later, one per cycle.
- Mode 1 inputs 0x40, 0x7F, 0x01 → outputs 0x7F, 0x55, 0x01; sweep of all 128 values in both modes, round-trip matches gray_pkg model.
- Alternate modes every cycle with out_ready random 50%: order, mode tagging and data exact; in_ready low only when both stages full.
- Hold out_ready=0 for 5 cycles after 3 offered words → 2 captured, in_ready=0, out_data stable; release → both drain on consecutive cycles, third word accepted on release cycle.
- Assert rst with two words in flight → out_valid=0, out_data=0 next cycle; post-reset word 0x12 mode 0 → 0x1B, no stale output.
- With GRAY_CODEC_STEP_CHK_EN: mode 0 binary 0..127 then wrap to 0 → step_err never set; mode 1 stream Gray 0x00 then 0x03 → step_err pulses one cycle after the 0x03 result transfers.
